// File: rtl/regfile_writeback_queue.sv
// Pending-write queue in front of the 32x32 register file write port.
// Drains one (rd, data) entry per cycle and serves youngest-wins bypass lookups.
module regfile_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4:0]                   in_rd,
    input  logic [31:0]                  in_data,
    input  logic                         wb_stall,
    output logic                         rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [31:0]                  rf_wdata,
    input  logic [4:0]                   lk_addr1,
    input  logic [4:0]                   lk_addr2,
    output logic                         lk_hit1,
    output logic [31:0]                  lk_data1,
    output logic                         lk_hit2,
    output logic [31:0]                  lk_data2,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic          push;
    logic          store;
    logic          pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    // Writes to x0 complete the handshake but never occupy an entry.
    assign store    = push && (in_rd != 5'd0);
    assign pop      = !empty && !wb_stall;

    assign rf_we    = pop;
    assign rf_waddr = empty ? 5'd0  : rd_mem[head];
    assign rf_wdata = empty ? 32'd0 : data_mem[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values; blocking here would race.
            if (store) tail <= tail + AW'(1);
            if (pop)   head <= head + AW'(1);
            case ({store, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; only slots between head and head+count are ever observed.
    always_ff @(posedge clk) begin
        if (store) begin
            rd_mem[tail]   <= in_rd;
            data_mem[tail] <= in_data;
        end
    end

    // Scan oldest to youngest so the last match (nearest tail) wins.
    function automatic logic [32:0] lookup(input logic [4:0] addr);
        logic [32:0]   r;
        logic [AW-1:0] idx;
        // NOTE: every variable gets a default before the loop, so no latch is inferred.
        r   = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (addr != 5'd0 && CW'(i) < count && rd_mem[idx] == addr)
                r = {1'b1, data_mem[idx]};
        end
        return r;
    endfunction

    always_comb begin
        {lk_hit1, lk_data1} = lookup(lk_addr1);
        {lk_hit2, lk_data2} = lookup(lk_addr2);
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench: stimulus queues expected register-file writes, a negedge
// monitor pops and compares them whenever rf_we is seen.
module tb_regfile_writeback_queue;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  lk_addr1;
    logic [4:0]  lk_addr2;
    logic        lk_hit1;
    logic [31:0] lk_data1;
    logic        lk_hit2;
    logic [31:0] lk_data2;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_q[$];

    regfile_writeback_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .wb_stall(wb_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .lk_addr1(lk_addr1), .lk_addr2(lk_addr2),
        .lk_hit1(lk_hit1), .lk_data1(lk_data1), .lk_hit2(lk_hit2), .lk_data2(lk_data2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one transfer for one cycle; returns just after the edge that sampled it.
    task automatic enq(input logic [4:0] rd, input logic [31:0] data, output logic acc);
        in_valid = 1'b1;
        in_rd    = rd;
        in_data  = data;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        if (acc && rd != 5'd0) exp_q.push_back('{rd: rd, data: data});
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rf_we) begin
                check("write_while_stalled", {31'd0, wb_stall}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("stray_write", {31'd0, rf_we}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.rd});
                    check("rf_wdata", rf_wdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [4:0]  rd_cur;
        logic [4:0]  a;

        rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0;
        wb_stall = 1'b0; lk_addr1 = '0; lk_addr2 = '0;

        // Reset state, checked while reset is asserted
        #3;
        check("rst_count",    {29'd0, count},    32'd0);
        check("rst_empty",    {31'd0, empty},    32'd1);
        check("rst_full",     {31'd0, full},     32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_rf_we",    {31'd0, rf_we},    32'd0);
        check("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_rf_wdata", rf_wdata,          32'd0);
        #9 rst_n = 1'b1;
        cycles(1);

        // Idle: no address hits
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            lk_addr1 = a;
            lk_addr2 = ~a;
            #1;
            check("idle_hit1",  {31'd0, lk_hit1}, 32'd0);
            check("idle_hit2",  {31'd0, lk_hit2}, 32'd0);
            check("idle_data1", lk_data1,         32'd0);
        end
        cycles(1);

        // Single write, one-cycle latency
        enq(5'd5, 32'hDEADBEEF, acc);
        lk_addr1 = 5'd5;
        @(negedge clk);
        check("t2_count",  {29'd0, count},   32'd1);
        check("t2_rf_we",  {31'd0, rf_we},   32'd1);
        check("t2_hit",    {31'd0, lk_hit1}, 32'd1);
        check("t2_lkdata", lk_data1,         32'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_empty",  {31'd0, empty},   32'd1);
        check("t2_nohit",  {31'd0, lk_hit1}, 32'd0);
        cycles(1);

        // Stalled fill with duplicate rd, youngest-wins lookup
        wb_stall = 1'b1;
        enq(5'd3, 32'h11, acc);
        enq(5'd7, 32'h22, acc);
        enq(5'd3, 32'h33, acc);
        enq(5'd9, 32'h44, acc);
        lk_addr1 = 5'd3;
        lk_addr2 = 5'd8;
        @(negedge clk);
        check("t3_full",     {31'd0, full},     32'd1);
        check("t3_in_ready", {31'd0, in_ready}, 32'd0);
        check("t3_count",    {29'd0, count},    32'd4);
        check("t3_hit1",     {31'd0, lk_hit1},  32'd1);
        check("t3_data1",    lk_data1,          32'h33);
        check("t3_hit2",     {31'd0, lk_hit2},  32'd0);
        check("t3_data2",    lk_data2,          32'd0);
        lk_addr1 = 5'd7;
        lk_addr2 = 5'd9;
        #1;
        check("t3_data7",    lk_data1,          32'h22);
        check("t3_data9",    lk_data2,          32'h44);
        @(posedge clk); #1;
        wb_stall = 1'b0;
        cycles(5);
        check("t3_drained",  {31'd0, empty},    32'd1);

        // Write to x0 is accepted but not stored
        lk_addr1 = 5'd0;
        enq(5'd0, 32'hFFFFFFFF, acc);
        check("t4_accepted", {31'd0, acc},      32'd1);
        @(negedge clk);
        check("t4_count",    {29'd0, count},    32'd0);
        check("t4_rf_we",    {31'd0, rf_we},    32'd0);
        check("t4_hit0",     {31'd0, lk_hit1},  32'd0);
        cycles(1);

        // Full with pop: no pass-through, then steady push/pop across the wrap
        wb_stall = 1'b1;
        for (int i = 1; i <= 4; i++) enq(5'(i), 32'hA0 + i, acc);
        wb_stall = 1'b0;
        in_valid = 1'b1;
        rd_cur   = 5'd10;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_rd   = rd_cur;
            in_data = 32'hB000_0000 | {27'd0, rd_cur};
            @(negedge clk);
            acc = in_ready;
            if (cyc == 0) begin
                check("t5_full_ready", {31'd0, in_ready}, 32'd0);
            end else begin
                check("t5_ready",      {31'd0, in_ready}, 32'd1);
                check("t5_count",      {29'd0, count},    32'd3);
            end
            @(posedge clk);
            if (acc) begin
                exp_q.push_back('{rd: rd_cur, data: in_data});
                rd_cur = rd_cur + 5'd1;
            end
            #1;
        end
        in_valid = 1'b0;
        cycles(5);
        check("t5_drained", {31'd0, empty}, 32'd1);

        // Reset with entries pending discards them
        wb_stall = 1'b1;
        enq(5'd20, 32'hC0, acc);
        enq(5'd21, 32'hC1, acc);
        enq(5'd22, 32'hC2, acc);
        @(negedge clk);
        check("t6_count_pre", {29'd0, count}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t6_count", {29'd0, count}, 32'd0);
        check("t6_rf_we", {31'd0, rf_we}, 32'd0);
        check("t6_empty", {31'd0, empty}, 32'd1);
        exp_q.delete();
        #8 rst_n = 1'b1;
        wb_stall = 1'b0;
        cycles(6);
        check("t6_still_empty", {31'd0, empty}, 32'd1);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
